aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule. It sits directly upstream of the Encrypt datapath.
//  It expands one 128-bit cipher key into the 11 round keys rk0..rk10, producing one

---
 rtl/aes_key_expand.sv | 180 ++++++++++++++++++
 tb/tb_aes_key_expand.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// aes_key_expand
//   Iterative AES-128 key schedule. One cipher key is expanded into the eleven
//   round keys rk0..rk10, one round key per clock, into a register file that
//   the round datapath reads combinationally by round index.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       request expansion of Key (only honoured in IDLE)
//   Key         128-bit cipher key, w0 = Key[127:96]
//   rd_round    read-port round index 0..10
//   rd_key      rk[rd_round]; zero for indices above 10
//   busy        high while expanding
//   done        one-cycle pulse after rk10 is written
//   keys_valid  rk0..rk10 hold a complete schedule
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for start; register file holds the last schedule (or zeros)
//   EXPAND | writing rk[round] from rk[round-1], one round per clock
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10,   // only the AES-128 value of 10 is meaningful
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] Key,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key,
    output logic             busy,
    output logic             done,
    output logic             keys_valid
);

    typedef enum logic [0:0] {IDLE, EXPAND} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [KEY_W-1:0] rk_q [0:NUM_ROUNDS];

    logic             wr_en;
    logic [3:0]       wr_idx;
    logic [KEY_W-1:0] wr_data;
    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;
    logic [31:0]      rot_w, sub_w, t_w, n0, n1, n2, n3;

    // Previous round key selected by mux rather than a computed array index,
    // so round_q == 0 in IDLE never produces an out-of-range access.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (round_q == 4'(i + 1)) prev_key = rk_q[i];
        end
    end

    always_comb begin
        rot_w = {prev_key[23:0], prev_key[31:24]};
        sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        t_w   = sub_w ^ {rcon(round_q), 24'h0};
        n0    = prev_key[127:96] ^ t_w;
        n1    = prev_key[95:64]  ^ n0;
        n2    = prev_key[63:32]  ^ n1;
        n3    = prev_key[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        wr_data = next_key;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    wr_data = Key;
                    round_d = 4'd1;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wr_en  = 1'b1;
                wr_idx = round_q;
                if (round_q == 4'(NUM_ROUNDS)) begin
                    round_d = 4'd0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
        end else begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                if (wr_en && wr_idx == 4'(i)) rk_q[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rd_round == 4'(i)) rd_key = rk_q[i];
        end
    end

    assign busy       = (state_q == EXPAND);
    assign done       = done_q;
    assign keys_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_KEY  = 128'h0;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] Key;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         busy;
    logic         done;
    logic         keys_valid;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } exp_t;

    exp_t sb[$];

    aes_key_expand dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Key        (Key),
        .rd_round   (rd_round),
        .rd_key     (rd_key),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sched(input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k10);
        sb.push_back('{4'd0, k0});
        sb.push_back('{4'd1, k1});
        sb.push_back('{4'd10, k10});
    endtask

    task automatic drain_sb(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_round = e.rnd;
            #1;
            vectors++;
            if (rd_key !== e.key) begin
                miscompares++;
                $display("FAIL %s rk%0d: got %h expected %h", tag, e.rnd, rd_key, e.key);
            end
        end
    endtask

    // Start one expansion and run until done or a 30-edge budget expires.
    // edges counts clock edges after the start edge; busy_cnt counts busy samples.
    task automatic run_expand(input logic [127:0] k, input bit disturb,
                              output int edges, output int busy_cnt, output logic valid_mid);
        Key   = k;
        start = 1'b1;
        tick();
        start     = 1'b0;
        edges     = 0;
        busy_cnt  = busy ? 1 : 0;
        valid_mid = keys_valid;
        while (!done && edges < 30) begin
            if (disturb && (edges == 3 || edges == 7)) begin
                start = 1'b1;
                Key   = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            tick();
            edges++;
            if (busy) busy_cnt++;
            if (edges == 5) valid_mid = valid_mid | keys_valid;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int edges, input int busy_cnt, input logic valid_mid);
        vectors++;
        if (edges !== 10) begin
            miscompares++;
            $display("FAIL %s done_latency: got %0d edges expected 10", tag, edges);
        end
        vectors++;
        if (busy_cnt !== 10) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected 10", tag, busy_cnt);
        end
        vectors++;
        if (valid_mid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s keys_valid_mid: got %b expected 0", tag, valid_mid);
        end
        vectors++;
        if (keys_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s keys_valid_at_done: got %b expected 1", tag, keys_valid);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || keys_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s after_done: got done=%b valid=%b expected done=0 valid=1", tag, done, keys_valid);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b0;
        Key      = '0;
        rd_round = 4'd0;
        #2;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || keys_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b done=%b valid=%b expected 0 0 0", busy, done, keys_valid);
        end
        for (int r = 0; r <= 10; r++) begin
            rd_round = 4'(r);
            #1;
            vectors++;
            if (rd_key !== 128'h0) begin
                miscompares++;
                $display("FAIL reset_rk%0d: got %h expected 0", r, rd_key);
            end
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        int e, b;
        logic vm;
        push_sched(FIPS_KEY, FIPS_RK1, FIPS_RK10);
        run_expand(FIPS_KEY, 1'b0, e, b, vm);
        check_run("fips", e, b, vm);
        drain_sb("fips");
    endtask

    task automatic test_zero_key();
        int e, b;
        logic vm;
        push_sched(ZERO_KEY, ZERO_RK1, ZERO_RK10);
        run_expand(ZERO_KEY, 1'b0, e, b, vm);
        check_run("zero", e, b, vm);
        drain_sb("zero");
        for (int r = 11; r <= 15; r++) begin
            rd_round = 4'(r);
            #1;
            vectors++;
            if (rd_key !== 128'h0) begin
                miscompares++;
                $display("FAIL rd_out_of_range idx%0d: got %h expected 0", r, rd_key);
            end
        end
    endtask

    task automatic test_ignore_start();
        int e, b;
        logic vm;
        push_sched(FIPS_KEY, FIPS_RK1, FIPS_RK10);
        run_expand(FIPS_KEY, 1'b1, e, b, vm);
        check_run("ignore", e, b, vm);
        drain_sb("ignore");
    endtask

    task automatic test_reset_abort();
        int e, b;
        logic vm;
        Key   = FIPS_KEY;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_before: got %b expected 1", busy);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || keys_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_flags: got busy=%b done=%b valid=%b expected 0 0 0", busy, done, keys_valid);
        end
        rd_round = 4'd0;
        #1;
        vectors++;
        if (rd_key !== 128'h0) begin
            miscompares++;
            $display("FAIL abort_rk0: got %h expected 0", rd_key);
        end
        rd_round = 4'd3;
        #1;
        vectors++;
        if (rd_key !== 128'h0) begin
            miscompares++;
            $display("FAIL abort_rk3: got %h expected 0", rd_key);
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if (keys_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_release: got valid=%b busy=%b expected 0 0", keys_valid, busy);
        end
        push_sched(ZERO_KEY, ZERO_RK1, ZERO_RK10);
        run_expand(ZERO_KEY, 1'b0, e, b, vm);
        check_run("post_abort", e, b, vm);
        drain_sb("post_abort");
    endtask

    task automatic test_done_restart();
        int edges;
        push_sched(FIPS_KEY, FIPS_RK1, FIPS_RK10);
        Key   = FIPS_KEY;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_first_done: got %b expected 1 within budget", done);
        end
        drain_sb("restart_first");
        Key   = ZERO_KEY;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (keys_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_accept: got valid=%b busy=%b expected 0 1", keys_valid, busy);
        end
        push_sched(ZERO_KEY, ZERO_RK1, ZERO_RK10);
        edges = 0;
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
        vectors++;
        if (edges !== 10) begin
            miscompares++;
            $display("FAIL restart_second_latency: got %0d edges expected 10", edges);
        end
        tick();
        drain_sb("restart_second");
    endtask

    task automatic test_back_to_back();
        int   last_done;
        int   n_done;
        int   busy_low;
        int   edges;
        exp_t e;
        rd_round  = 4'd10;
        Key       = FIPS_KEY;
        start     = 1'b1;
        last_done = 0;
        n_done    = 0;
        busy_low  = 0;
        repeat (3) sb.push_back('{4'd10, FIPS_RK10});
        tick();
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (!busy) busy_low++;
            if (done) begin
                n_done++;
                vectors++;
                if (t - last_done !== ((n_done == 1) ? 10 : 11)) begin
                    miscompares++;
                    $display("FAIL b2b_done_spacing: got %0d expected %0d", t - last_done, (n_done == 1) ? 10 : 11);
                end
                last_done = t;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    vectors++;
                    if (rd_key !== e.key) begin
                        miscompares++;
                        $display("FAIL b2b_rk10: got %h expected %h", rd_key, e.key);
                    end
                end
            end
        end
        vectors++;
        if (n_done !== 3 || busy_low !== 3) begin
            miscompares++;
            $display("FAIL b2b_counts: got dones=%0d busy_low=%0d expected 3 3", n_done, busy_low);
        end
        start = 1'b0;
        edges = 0;
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
        tick();
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_ignore_start();
        test_reset_abort();
        test_done_restart();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
